// File: rtl/sudoku_pkg.sv
// rtl/sudoku_pkg.sv - shared Sudoku game state encoding
package sudoku_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE      = 3'd0,
        GEN_RAND  = 3'd1,
        SET_BOARD = 3'd2,
        SET_DIFF  = 3'd3,
        PLAY      = 3'd4,
        CHECK     = 3'd5,
        WIN       = 3'd6,
        TRY_AGAIN = 3'd7
    } state_t;

endpackage

// File: rtl/main_fsm_if.sv
// rtl/main_fsm_if.sv - user inputs, datapath verdict and phase flags of the game FSM
interface main_fsm_if;
    import sudoku_pkg::*;

    logic               enter;
    logic               check;
    logic               solved;
    logic               gen_rand_flag;
    logic               set_board_flag;
    logic               set_diff_flag;
    logic               play_flag;
    logic               check_flag;
    logic               win_flag;
    logic               try_again_flag;
    logic [STATE_W-1:0] state;

    modport master (
        output enter, check, solved,
        input  gen_rand_flag, set_board_flag, set_diff_flag, play_flag,
               check_flag, win_flag, try_again_flag, state
    );

    modport slave (
        input  enter, check, solved,
        output gen_rand_flag, set_board_flag, set_diff_flag, play_flag,
               check_flag, win_flag, try_again_flag, state
    );

endinterface

// File: rtl/main_fsm.sv
// rtl/main_fsm.sv - Moore control FSM sequencing a Sudoku game
module main_fsm
    import sudoku_pkg::*;
(
    input  logic       clka,
    input  logic       restart,
    main_fsm_if.slave  bus
);

    state_t cur;

    always_ff @(posedge clka) begin
        if (restart) begin
            cur <= IDLE;
        end else begin
            case (cur)
                IDLE:      if (bus.enter) cur <= GEN_RAND;
                GEN_RAND:  cur <= SET_BOARD;
                SET_BOARD: if (bus.enter) cur <= SET_DIFF;
                SET_DIFF:  if (bus.enter) cur <= PLAY;
                // enter alone in PLAY is a guess commit handled by the datapath
                PLAY:      if (bus.check) cur <= CHECK;
                CHECK:     cur <= bus.solved ? WIN : TRY_AGAIN;
                WIN:       if (bus.enter) cur <= IDLE;
                TRY_AGAIN: begin
                    if (bus.check)      cur <= CHECK;
                    else if (bus.enter) cur <= PLAY;
                end
                default:   cur <= IDLE;
            endcase
        end
    end

    assign bus.state          = cur;
    assign bus.gen_rand_flag  = (cur == GEN_RAND);
    assign bus.set_board_flag = (cur == SET_BOARD);
    assign bus.set_diff_flag  = (cur == SET_DIFF);
    assign bus.play_flag      = (cur == PLAY);
    assign bus.check_flag     = (cur == CHECK);
    assign bus.win_flag       = (cur == WIN);
    assign bus.try_again_flag = (cur == TRY_AGAIN);

endmodule

// File: tb/tb_main_fsm.sv
// tb/tb_main_fsm.sv - self-checking bench for main_fsm against a rule-level model
module tb_main_fsm;

    logic clka = 1'b0;
    logic restart;
    int   n_assert = 0;
    int   n_fail   = 0;
    logic [2:0] exp_state = 3'bx;

    main_fsm_if bus ();

    main_fsm dut (
        .clka    (clka),
        .restart (restart),
        .bus     (bus)
    );

    always #5 clka = ~clka;

    // Game rules written directly from the user-level flow description.
    function automatic logic [2:0] model_next(input logic [2:0] st, input logic r,
                                              input logic e, input logic c, input logic s);
        if (r) return 3'd0;
        if (st == 3'd1) return 3'd2;
        if (st == 3'd5) return s ? 3'd6 : 3'd7;
        if ((st == 3'd4 || st == 3'd7) && c) return 3'd5;
        if (!e) return st;
        case (st)
            3'd0:    return 3'd1;
            3'd2:    return 3'd3;
            3'd3:    return 3'd4;
            3'd6:    return 3'd0;
            3'd7:    return 3'd4;
            default: return st;
        endcase
    endfunction

    function automatic logic [6:0] model_flags(input logic [2:0] st);
        logic [6:0] f;
        f = '0;
        if (st != 3'd0) f[st-1] = 1'b1;
        return f;
    endfunction

    function automatic logic [6:0] dut_flags();
        return {bus.try_again_flag, bus.win_flag, bus.check_flag, bus.play_flag,
                bus.set_diff_flag, bus.set_board_flag, bus.gen_rand_flag};
    endfunction

    task automatic step(input logic r, input logic e, input logic c, input logic s);
        @(negedge clka);
        restart    = r;
        bus.enter  = e;
        bus.check  = c;
        bus.solved = s;
        @(posedge clka);
        #1;
        exp_state = model_next(exp_state, r, e, c, s);
    endtask

    task automatic test_reset();
        restart = 1'b1; bus.enter = 1'b0; bus.check = 1'b0; bus.solved = 1'b0;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        n_assert++;
        if (bus.state !== 3'd0) begin
            n_fail++; $display("FAIL reset_state got %0d want 0", bus.state);
        end
        n_assert++;
        if (dut_flags() !== 7'b0) begin
            n_fail++; $display("FAIL reset_flags got %b want 0000000", dut_flags());
        end
        step(0, 0, 0, 0);
        n_assert++;
        if (bus.state !== 3'd0 || dut_flags() !== 7'b0) begin
            n_fail++; $display("FAIL reset_idle got %0d/%b want 0/0000000", bus.state, dut_flags());
        end
    endtask

    task automatic test_main_path();
        logic [3:0] seq [9] = '{4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0100,
                                4'b0000, 4'b0100, 4'b0010, 4'b0000};
        int want [9] = '{1, 2, 3, 3, 4, 4, 4, 5, 7};
        for (int i = 0; i < 9; i++) begin
            step(seq[i][3], seq[i][2], seq[i][1], seq[i][0]);
            n_assert++;
            if (int'(bus.state) != want[i] || bus.state !== exp_state) begin
                n_fail++; $display("FAIL main_path[%0d] got %0d want %0d", i, bus.state, want[i]);
            end
            n_assert++;
            if (dut_flags() !== model_flags(exp_state)) begin
                n_fail++; $display("FAIL main_flags[%0d] got %b want %b", i, dut_flags(), model_flags(exp_state));
            end
        end
        n_assert++;
        if (bus.try_again_flag !== 1'b1) begin
            n_fail++; $display("FAIL main_try_again got %b want 1", bus.try_again_flag);
        end
    endtask

    task automatic test_priority();
        // Entered from TRY_AGAIN left by the main path.
        logic [3:0] seq [4] = '{4'b0110, 4'b0000, 4'b0100, 4'b0110};
        int want [4] = '{5, 7, 4, 5};
        for (int i = 0; i < 4; i++) begin
            step(seq[i][3], seq[i][2], seq[i][1], seq[i][0]);
            n_assert++;
            if (int'(bus.state) != want[i] || bus.state !== exp_state) begin
                n_fail++; $display("FAIL priority[%0d] got %0d want %0d", i, bus.state, want[i]);
            end
        end
    endtask

    task automatic test_win_hold();
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0, 0);
            n_assert++;
            if (bus.state !== 3'd2 || bus.set_board_flag !== 1'b1) begin
                n_fail++; $display("FAIL hold_set_board[%0d] got %0d want 2", k, bus.state);
            end
        end
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0, 0);
            n_assert++;
            if (bus.state !== 3'd4 || bus.play_flag !== 1'b1) begin
                n_fail++; $display("FAIL hold_play[%0d] got %0d want 4", k, bus.state);
            end
        end
        step(0, 0, 1, 0);
        n_assert++;
        if (bus.state !== 3'd5 || bus.check_flag !== 1'b1) begin
            n_fail++; $display("FAIL win_check got %0d want 5", bus.state);
        end
        step(0, 0, 0, 1);
        n_assert++;
        if (bus.state !== 3'd6 || bus.win_flag !== 1'b1) begin
            n_fail++; $display("FAIL win_state got %0d want 6", bus.state);
        end
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0, 0);
            n_assert++;
            if (bus.state !== 3'd6) begin
                n_fail++; $display("FAIL hold_win[%0d] got %0d want 6", k, bus.state);
            end
        end
        step(0, 1, 0, 0);
        n_assert++;
        if (bus.state !== 3'd0 || dut_flags() !== 7'b0) begin
            n_fail++; $display("FAIL win_exit got %0d want 0", bus.state);
        end
    endtask

    task automatic test_mid_reset();
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        n_assert++;
        if (bus.state !== 3'd0 || dut_flags() !== 7'b0) begin
            n_fail++; $display("FAIL reset_in_set_diff got %0d/%b want 0", bus.state, dut_flags());
        end
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        step(1, 1, 0, 1);
        n_assert++;
        if (bus.state !== 3'd0 || dut_flags() !== 7'b0) begin
            n_fail++; $display("FAIL reset_in_check got %0d/%b want 0", bus.state, dut_flags());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 24) == 0, 1'($urandom), 1'($urandom_range(0, 3) == 0),
                 1'($urandom));
            n_assert++;
            if (bus.state !== exp_state || dut_flags() !== model_flags(exp_state)) begin
                n_fail++;
                $display("FAIL random[%0d] got %0d/%b want %0d/%b", i, bus.state, dut_flags(),
                         exp_state, model_flags(exp_state));
            end
        end
    endtask

    initial begin
        test_reset();
        test_main_path();
        test_priority();
        test_win_hold();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
